// File: rtl/regbank_seq_pkg.sv
// Shared definitions for the register-bank command sequencer: widths, command
// opcodes, sequencer states, bank write-mode codes and the command payload.
package regbank_seq_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned STAT_W = 16;

    // Command opcodes as presented on cmd_op
    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_MOVE  = 2'b11
    } op_e;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        OPV   = 3'd2,
        WR    = 3'd3,
        MV_RD = 3'd4,
        MV_WR = 3'd5
    } state_e;

    // Bank write-mode codes carried on rb_endreg
    typedef enum logic [1:0] {
        WM_FULL = 2'b00,
        WM_LO   = 2'b01,
        WM_HI   = 2'b10,
        WM_SWAP = 2'b11
    } wmode_e;

    // Command payload sampled at acceptance
    typedef struct packed {
        logic [ADDR_W-1:0] dst;
        logic [ADDR_W-1:0] src_a;
        logic [ADDR_W-1:0] src_b;
        logic [1:0]        cnst;
        logic [1:0]        mode;
        logic [DATA_W-1:0] data;
    } cmd_t;

    // Write-side fields that must survive past acceptance (used in WR / MV_WR)
    typedef struct packed {
        logic [ADDR_W-1:0] dst;
        logic [1:0]        mode;
        logic [DATA_W-1:0] data;
    } wr_t;

    // Registered bank control bundle (everything except rb_inA)
    typedef struct packed {
        logic              regwen;
        logic              enrreg_a;
        logic              enrreg_b;
        logic              cnst_a;
        logic              cnst_b;
        logic [ADDR_W-1:0] selwreg;
        logic [ADDR_W-1:0] sel_a;
        logic [ADDR_W-1:0] sel_b;
        logic [1:0]        endreg;
    } ctrl_t;

endpackage

// File: rtl/regbank_seq_stats.sv
// Saturating per-opcode acceptance counters for the sequencer.
// Ports: clock/reset (async active-low); inc_rd/inc_wr/inc_mv one-cycle
// increment strobes; stat_rd/stat_wr/stat_mv 16-bit saturating counts.
module regbank_seq_stats
    import regbank_seq_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              inc_rd,
    input  logic              inc_wr,
    input  logic              inc_mv,
    output logic [STAT_W-1:0] stat_rd,
    output logic [STAT_W-1:0] stat_wr,
    output logic [STAT_W-1:0] stat_mv
);

    // Counters stick at all-ones instead of wrapping
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_rd <= '0;
            stat_wr <= '0;
            stat_mv <= '0;
        end else begin
            if (inc_rd && (stat_rd != '1)) stat_rd <= stat_rd + STAT_W'(1);
            if (inc_wr && (stat_wr != '1)) stat_wr <= stat_wr + STAT_W'(1);
            if (inc_mv && (stat_mv != '1)) stat_mv <= stat_mv + STAT_W'(1);
        end
    end

endmodule

// File: rtl/regbank_seq.sv
// Command sequencer and sole master of the 16x64 register bank controls.
// Accepts one READ/WRITE/MOVE/NOP command at a time (cmd_valid/cmd_ready),
// produces timed bank pulses (rb_*), and hands READ operands downstream
// (opd_valid/opd_ready). busy flags any non-idle state.
// Optional REGBANK_SEQ_STATS_EN adds stat_rd/stat_wr/stat_mv counters.
// Ports: clock, reset (async active-low); cmd_* command channel; rb_* bank
// controls plus rb_outA bank read-back; opd_valid/opd_ready; busy; stat_*.
module regbank_seq
    import regbank_seq_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W-1:0] cmd_srcA,
    input  logic [ADDR_W-1:0] cmd_srcB,
    input  logic [1:0]        cmd_cnst,
    input  logic [1:0]        cmd_mode,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rb_regwen,
    output logic              rb_enrregA,
    output logic              rb_enrregB,
    output logic              rb_cnstA,
    output logic              rb_cnstB,
    output logic [ADDR_W-1:0] rb_selwreg,
    output logic [ADDR_W-1:0] rb_seloutA,
    output logic [ADDR_W-1:0] rb_seloutB,
    output logic [1:0]        rb_endreg,
    output logic [DATA_W-1:0] rb_inA,
    input  logic [DATA_W-1:0] rb_outA,
    output logic              opd_valid,
    input  logic              opd_ready,
    output logic              busy
`ifdef REGBANK_SEQ_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_rd,
    output logic [STAT_W-1:0] stat_wr,
    output logic [STAT_W-1:0] stat_mv
`endif
);

    state_e state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;
    wr_t    wr_q;
    cmd_t   cmd_in;
    op_e    op_in;
    logic   accept;
    logic   ready_q, ready_d;
    logic   opd_valid_q, opd_valid_d;
    logic   busy_q, busy_d;
    logic   mv_wr_q, mv_wr_d;

    assign cmd_in = '{dst: cmd_dst, src_a: cmd_srcA, src_b: cmd_srcB,
                      cnst: cmd_cnst, mode: cmd_mode, data: cmd_data};
    assign op_in  = op_e'(cmd_op);
    assign accept = cmd_valid & ready_q;

    // Next state, and bank controls decoded from the state being entered so
    // that each pulse is registered and lines up with its state
    always_comb begin
        state_d     = state_q;
        ctrl_d      = '0;
        ready_d     = 1'b0;
        opd_valid_d = 1'b0;
        busy_d      = 1'b0;
        mv_wr_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (op_in)
                        OP_READ:  state_d = RD;
                        OP_WRITE: state_d = WR;
                        OP_MOVE:  state_d = MV_RD;
                        default:  state_d = IDLE;
                    endcase
                end
            end
            RD:      state_d = OPV;
            OPV:     if (opd_ready) state_d = IDLE;
            WR:      state_d = IDLE;
            MV_RD:   state_d = MV_WR;
            MV_WR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // RD/WR/MV_RD are only entered on acceptance, so take fields straight
        // from the command; MV_WR uses the fields captured at acceptance
        case (state_d)
            RD: begin
                ctrl_d.enrreg_a = 1'b1;
                ctrl_d.enrreg_b = 1'b1;
                ctrl_d.sel_a    = cmd_in.src_a;
                ctrl_d.sel_b    = cmd_in.src_b;
                ctrl_d.cnst_a   = cmd_in.cnst[0];
                ctrl_d.cnst_b   = cmd_in.cnst[1];
            end
            WR: begin
                ctrl_d.regwen  = 1'b1;
                ctrl_d.selwreg = cmd_in.dst;
                ctrl_d.endreg  = cmd_in.mode;
            end
            MV_RD: begin
                ctrl_d.enrreg_a = 1'b1;
                ctrl_d.sel_a    = cmd_in.src_a;
                ctrl_d.cnst_a   = cmd_in.cnst[0];
            end
            MV_WR: begin
                ctrl_d.regwen  = 1'b1;
                ctrl_d.selwreg = wr_q.dst;
                ctrl_d.endreg  = wr_q.mode;
            end
            default: ;
        endcase

        ready_d     = (state_d == IDLE);
        opd_valid_d = (state_d == OPV);
        busy_d      = (state_d != IDLE);
        mv_wr_d     = (state_d == MV_WR);
    end

    // State and registered outputs; reset also kills any write in flight
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ctrl_q      <= '0;
            wr_q        <= '0;
            ready_q     <= 1'b0;
            opd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            mv_wr_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            ready_q     <= ready_d;
            opd_valid_q <= opd_valid_d;
            busy_q      <= busy_d;
            mv_wr_q     <= mv_wr_d;
            if (accept) begin
                wr_q <= '{dst: cmd_in.dst, mode: cmd_in.mode, data: cmd_in.data};
            end
        end
    end

    assign cmd_ready  = ready_q;
    assign opd_valid  = opd_valid_q;
    assign busy       = busy_q;
    assign rb_regwen  = ctrl_q.regwen;
    assign rb_enrregA = ctrl_q.enrreg_a;
    assign rb_enrregB = ctrl_q.enrreg_b;
    assign rb_cnstA   = ctrl_q.cnst_a;
    assign rb_cnstB   = ctrl_q.cnst_b;
    assign rb_selwreg = ctrl_q.selwreg;
    assign rb_seloutA = ctrl_q.sel_a;
    assign rb_seloutB = ctrl_q.sel_b;
    assign rb_endreg  = ctrl_q.endreg;

    // MOVE writes back what the bank just read; otherwise the captured data
    assign rb_inA = mv_wr_q ? rb_outA : wr_q.data;

`ifdef REGBANK_SEQ_STATS_EN
    logic inc_rd, inc_wr, inc_mv;

    assign inc_rd = accept && (op_in == OP_READ);
    assign inc_wr = accept && (op_in == OP_WRITE);
    assign inc_mv = accept && (op_in == OP_MOVE);

    regbank_seq_stats u_stats (
        .clock   (clock),
        .reset   (reset),
        .inc_rd  (inc_rd),
        .inc_wr  (inc_wr),
        .inc_mv  (inc_mv),
        .stat_rd (stat_rd),
        .stat_wr (stat_wr),
        .stat_mv (stat_mv)
    );
`endif

endmodule

// File: tb/tb_regbank_seq.sv
// Bench for regbank_seq: behavioural register bank on the rb_* ports, a
// directed vector table, hand-written multi-cycle sequences and randomized
// commands checked against a command-level register model.
module tb_regbank_seq;
    import regbank_seq_pkg::*;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = '0;
    logic [3:0]        cmd_dst = '0, cmd_srcA = '0, cmd_srcB = '0;
    logic [1:0]        cmd_cnst = '0, cmd_mode = '0;
    logic [63:0]       cmd_data = '0;
    logic              rb_regwen, rb_enrregA, rb_enrregB, rb_cnstA, rb_cnstB;
    logic [3:0]        rb_selwreg, rb_seloutA, rb_seloutB;
    logic [1:0]        rb_endreg;
    logic [63:0]       rb_inA, rb_outA, rb_outB;
    logic              opd_valid, busy;
    logic              opd_ready = 1'b0;
    logic              bank_rst = 1'b1;
`ifdef REGBANK_SEQ_STATS_EN
    logic [15:0]       stat_rd, stat_wr, stat_mv;
    int                n_rd = 0, n_wr = 0, n_mv = 0;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int overlap = 0;
    int regwen_cnt = 0;

    logic [63:0] bank     [16];
    logic [63:0] ref_regs [16];

    typedef struct {
        op_e         op;
        logic [3:0]  dst, a, b;
        logic [1:0]  cnst, mode;
        logic [63:0] data, exp_a, exp_b;
        int          hold;
    } vec_t;

    regbank_seq dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dst(cmd_dst), .cmd_srcA(cmd_srcA), .cmd_srcB(cmd_srcB),
        .cmd_cnst(cmd_cnst), .cmd_mode(cmd_mode), .cmd_data(cmd_data),
        .rb_regwen(rb_regwen), .rb_enrregA(rb_enrregA), .rb_enrregB(rb_enrregB),
        .rb_cnstA(rb_cnstA), .rb_cnstB(rb_cnstB), .rb_selwreg(rb_selwreg),
        .rb_seloutA(rb_seloutA), .rb_seloutB(rb_seloutB), .rb_endreg(rb_endreg),
        .rb_inA(rb_inA), .rb_outA(rb_outA),
        .opd_valid(opd_valid), .opd_ready(opd_ready), .busy(busy)
`ifdef REGBANK_SEQ_STATS_EN
        , .stat_rd(stat_rd), .stat_wr(stat_wr), .stat_mv(stat_mv)
`endif
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Constant generator of the bank: code 15 is all ones, 0..7 a single byte-lane one
    function automatic logic [63:0] cval(input logic [3:0] c);
        if (c == 4'hF) return '1;
        if (c < 4'd8)  return 64'(1) << (8 * int'(c));
        return 64'(c);
    endfunction

    // Bank write-mode semantics
    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                          input logic [1:0] mode);
        case (mode)
            2'd1:    return {old[63:32], nw[31:0]};
            2'd2:    return {nw[63:32], old[31:0]};
            2'd3:    return {nw[31:0], nw[63:32]};
            default: return nw;
        endcase
    endfunction

    // Behavioural register bank with registered read ports
    always @(posedge clock) begin
        if (bank_rst) begin
            for (int i = 0; i < 16; i++) bank[i] <= '0;
            rb_outA <= '0;
            rb_outB <= '0;
        end else begin
            if (rb_regwen)  bank[rb_selwreg] <= merge(bank[rb_selwreg], rb_inA, rb_endreg);
            if (rb_enrregA) rb_outA <= rb_cnstA ? cval(rb_seloutA) : bank[rb_seloutA];
            if (rb_enrregB) rb_outB <= rb_cnstB ? cval(rb_seloutB) : bank[rb_seloutB];
        end
    end

    always @(negedge clock) begin
        if (rb_regwen && (rb_enrregA || rb_enrregB)) overlap++;
        if (rb_regwen) regwen_cnt++;
    end

    initial begin
        #50_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] opnd(input logic [3:0] idx, input logic c);
        return c ? cval(idx) : ref_regs[idx];
    endfunction

    // Offer a command and wait (bounded) for its acceptance edge
    task automatic send(input vec_t v, output int acc);
        int n;
        @(negedge clock);
        cmd_op = v.op; cmd_dst = v.dst; cmd_srcA = v.a; cmd_srcB = v.b;
        cmd_cnst = v.cnst; cmd_mode = v.mode; cmd_data = v.data;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 64'(cmd_ready), 64'(1));
            cmd_valid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clock);
        #1;
        acc = cyc;
        cmd_valid = 1'b0;
        opd_ready = 1'b0;
        // Scramble fields: the sequencer must use what it captured
        cmd_op = 2'($urandom); cmd_dst = 4'($urandom); cmd_srcA = 4'($urandom);
        cmd_srcB = 4'($urandom); cmd_cnst = 2'($urandom); cmd_mode = 2'($urandom);
        cmd_data = {$urandom, $urandom};
`ifdef REGBANK_SEQ_STATS_EN
        if (v.op == OP_READ)  n_rd++;
        if (v.op == OP_WRITE) n_wr++;
        if (v.op == OP_MOVE)  n_mv++;
`endif
    endtask

    // Issue one command and check its full bank/handshake timing
    task automatic run_vec(input vec_t v, input string tag);
        int acc;
        logic [63:0] src;
        logic [63:0] hold_a, hold_b;
        src = opnd(v.a, v.cnst[0]);
        send(v, acc);
        if (acc < 0) return;
        @(negedge clock);
        case (v.op)
            OP_WRITE: begin
                chk({tag, "_wr_ctl"}, 64'({rb_regwen, rb_enrregA, rb_enrregB, rb_selwreg, rb_endreg}),
                    64'({1'b1, 1'b0, 1'b0, v.dst, v.mode}));
                chk({tag, "_wr_data"}, rb_inA, v.data);
                chk({tag, "_wr_busy"}, 64'({busy, cmd_ready}), 64'({1'b1, 1'b0}));
                ref_regs[v.dst] = merge(ref_regs[v.dst], v.data, v.mode);
                @(negedge clock);
                chk({tag, "_wr_done"}, 64'({rb_regwen, cmd_ready, busy}), 64'({1'b0, 1'b1, 1'b0}));
            end
            OP_MOVE: begin
                chk({tag, "_mv_rd"}, 64'({rb_regwen, rb_enrregA, rb_enrregB, rb_cnstA, rb_seloutA}),
                    64'({1'b0, 1'b1, 1'b0, v.cnst[0], v.a}));
                @(negedge clock);
                chk({tag, "_mv_wr"}, 64'({rb_regwen, rb_enrregA, rb_selwreg, rb_endreg}),
                    64'({1'b1, 1'b0, v.dst, v.mode}));
                chk({tag, "_mv_data"}, rb_inA, src);
                ref_regs[v.dst] = merge(ref_regs[v.dst], src, v.mode);
                @(negedge clock);
                chk({tag, "_mv_done"}, 64'({rb_regwen, cmd_ready}), 64'({1'b0, 1'b1}));
            end
            OP_READ: begin
                chk({tag, "_rd_ctl"},
                    64'({rb_enrregA, rb_enrregB, rb_cnstA, rb_cnstB, rb_seloutA, rb_seloutB, opd_valid}),
                    64'({1'b1, 1'b1, v.cnst[0], v.cnst[1], v.a, v.b, 1'b0}));
                @(negedge clock);
                chk({tag, "_rd_valid"}, 64'({opd_valid, rb_enrregA, rb_enrregB}), 64'({1'b1, 1'b0, 1'b0}));
                chk({tag, "_rd_a"}, rb_outA, v.exp_a);
                chk({tag, "_rd_b"}, rb_outB, v.exp_b);
                hold_a = rb_outA;
                hold_b = rb_outB;
                for (int h = 0; h < v.hold; h++) begin
                    @(negedge clock);
                    chk({tag, "_hold_ctl"}, 64'({opd_valid, cmd_ready, busy}), 64'({1'b1, 1'b0, 1'b1}));
                    chk({tag, "_hold_opd"}, rb_outA ^ rb_outB, hold_a ^ hold_b);
                end
                opd_ready = 1'b1;
                @(posedge clock);
                #1;
                opd_ready = 1'b0;
                chk({tag, "_rd_done"}, 64'({opd_valid, cmd_ready, busy}), 64'({1'b0, 1'b1, 1'b0}));
            end
            default: begin
                chk({tag, "_nop"}, 64'({busy, cmd_ready, rb_regwen, rb_enrregA, rb_enrregB}),
                    64'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
            end
        endcase
    endtask

    initial begin
        vec_t tbl[10];
        vec_t v;
        int   a0, a1, a2, rw0;
        logic [63:0] old7;

        for (int i = 0; i < 16; i++) ref_regs[i] = '0;

        // Directed table: {op, dst, srcA, srcB, cnst, mode, data, expA, expB, hold}
        tbl[0] = '{OP_WRITE, 4'd3, 4'd0, 4'd0, 2'b00, 2'b00, 64'h1122334455667788, 64'h0, 64'h0, 0};
        tbl[1] = '{OP_READ,  4'd0, 4'd3, 4'd0, 2'b00, 2'b00, 64'h0, 64'h1122334455667788, 64'h0, 0};
        tbl[2] = '{OP_READ,  4'd0, 4'd4, 4'hF, 2'b11, 2'b00, 64'h0, 64'h0000000100000000, 64'hFFFFFFFFFFFFFFFF, 5};
        tbl[3] = '{OP_MOVE,  4'd7, 4'd3, 4'd0, 2'b00, 2'b11, 64'h0, 64'h0, 64'h0, 0};
        tbl[4] = '{OP_READ,  4'd0, 4'd7, 4'd3, 2'b00, 2'b00, 64'h0, 64'h5566778811223344, 64'h1122334455667788, 1};
        tbl[5] = '{OP_WRITE, 4'd5, 4'd0, 4'd0, 2'b00, 2'b01, 64'hAAAAAAAABBBBBBBB, 64'h0, 64'h0, 0};
        tbl[6] = '{OP_WRITE, 4'd5, 4'd0, 4'd0, 2'b00, 2'b10, 64'hCCCCCCCCDDDDDDDD, 64'h0, 64'h0, 0};
        tbl[7] = '{OP_READ,  4'd0, 4'd5, 4'd7, 2'b00, 2'b00, 64'h0, 64'hCCCCCCCCBBBBBBBB, 64'h5566778811223344, 0};
        tbl[8] = '{OP_MOVE,  4'd9, 4'd2, 4'd0, 2'b01, 2'b00, 64'h0, 64'h0, 64'h0, 0};
        tbl[9] = '{OP_READ,  4'd0, 4'd9, 4'd0, 2'b10, 2'b00, 64'h0, 64'h0000000000010000, 64'h1, 2};

        // Reset state
        #1 reset = 1'b0;
        #1;
        chk("reset_ctl", 64'({rb_regwen, rb_enrregA, rb_enrregB, rb_cnstA, rb_cnstB,
                              rb_selwreg, rb_seloutA, rb_seloutB, rb_endreg}), 64'h0);
        chk("reset_hs", 64'({cmd_ready, opd_valid, busy}), 64'h0);
        chk("reset_inA", rb_inA, 64'h0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        bank_rst = 1'b0;
        reset = 1'b1;

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("tbl%0d", i));

        v = '{OP_NOP, 4'd1, 4'd1, 4'd1, 2'b00, 2'b00, 64'h1, 64'h0, 64'h0, 0};
        run_vec(v, "nop");
        chk("nop_no_write", ref_regs[1] ^ bank[1], 64'h0);

        // Back-to-back WRITE, WRITE, MOVE with cmd_valid offered continuously
        rw0 = regwen_cnt;
        v = '{OP_WRITE, 4'd10, 4'd0, 4'd0, 2'b00, 2'b00, 64'h0123456789ABCDEF, 64'h0, 64'h0, 0};
        send(v, a0);
        ref_regs[10] = 64'h0123456789ABCDEF;
        v = '{OP_WRITE, 4'd11, 4'd0, 4'd0, 2'b00, 2'b00, 64'hFEDCBA9876543210, 64'h0, 64'h0, 0};
        send(v, a1);
        ref_regs[11] = 64'hFEDCBA9876543210;
        v = '{OP_MOVE, 4'd12, 4'd10, 4'd0, 2'b00, 2'b00, 64'h0, 64'h0, 64'h0, 0};
        send(v, a2);
        ref_regs[12] = ref_regs[10];
        repeat (3) @(negedge clock);
        chk("b2b_gap1", 64'(a1 - a0), 64'd2);
        chk("b2b_gap2", 64'(a2 - a1), 64'd2);
        chk("b2b_regwen_pulses", 64'(regwen_cnt - rw0), 64'd3);
        v = '{OP_READ, 4'd0, 4'd12, 4'd11, 2'b00, 2'b00, 64'h0, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 0};
        run_vec(v, "b2b_rd");

        // Reset asserted while in MV_RD: write must be dropped
        old7 = ref_regs[7];
        v = '{OP_MOVE, 4'd7, 4'd0, 4'd0, 2'b01, 2'b00, 64'h0, 64'h0, 64'h0, 0};
        send(v, a0);
        #2 reset = 1'b0;
        #1;
        chk("mvrst_ctl", 64'({rb_regwen, rb_enrregA, rb_enrregB, rb_cnstA, rb_cnstB,
                              rb_selwreg, rb_seloutA, rb_seloutB, rb_endreg}), 64'h0);
        chk("mvrst_hs", 64'({cmd_ready, opd_valid, busy}), 64'h0);
        chk("mvrst_inA", rb_inA, 64'h0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("mvrst_dst_kept", bank[7], old7);
        reset = 1'b1;
`ifdef REGBANK_SEQ_STATS_EN
        n_rd = 0; n_wr = 0; n_mv = 0;
`endif
        v = '{OP_READ, 4'd0, 4'd7, 4'd7, 2'b00, 2'b00, 64'h0, old7, old7, 0};
        run_vec(v, "mvrst_rd");

        // Randomized commands against the register model
        for (int i = 0; i < 150; i++) begin
            v.op   = op_e'($urandom_range(0, 3));
            v.dst  = 4'($urandom);
            v.a    = 4'($urandom);
            v.b    = 4'($urandom);
            v.cnst = 2'($urandom);
            v.mode = 2'($urandom);
            v.data = {$urandom, $urandom};
            v.hold = $urandom_range(0, 3);
            v.exp_a = opnd(v.a, v.cnst[0]);
            v.exp_b = opnd(v.b, v.cnst[1]);
            opd_ready = 1'($urandom);
            run_vec(v, $sformatf("rnd%0d", i));
        end

        chk("no_regwen_enrreg_overlap", 64'(overlap), 64'd0);

`ifdef REGBANK_SEQ_STATS_EN
        chk("stat_rd", 64'(stat_rd), 64'(n_rd));
        chk("stat_wr", 64'(stat_wr), 64'(n_wr));
        chk("stat_mv", 64'(stat_mv), 64'(n_mv));
        @(negedge clock) reset = 1'b0;
        @(negedge clock) reset = 1'b1;
        chk("stat_clear", 64'({stat_rd, stat_wr, stat_mv}), 64'h0);
        cmd_op = OP_WRITE; cmd_dst = 4'd1; cmd_mode = 2'b00; cmd_data = 64'h5;
        cmd_valid = 1'b1;
        repeat (140000) @(posedge clock);
        @(negedge clock) cmd_valid = 1'b0;
        repeat (2) @(negedge clock);
        chk("stat_wr_sat", 64'(stat_wr), 64'hFFFF);
        chk("stat_rd_zero", 64'(stat_rd), 64'h0);
        chk("stat_mv_zero", 64'(stat_mv), 64'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
